regfile_dump_reader: RTL and testbench



---
 rtl/regfile_pkg.sv | 15 +
 rtl/register_file.sv | 25 ++
 rtl/regfile_dump_reader.sv | 102 ++++++++++
 tb/tb_regfile_dump_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the dump-reader state encoding.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/register_file.sv
// Three-port register file: two combinational reads, one write on the rising CLK edge.
// Zero read latency. No backpressure.
module register_file
  import regfile_pkg::*;
(
  input  logic              CLK,
  input  logic              WE3,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  logic [DATA_W-1:0] rf [NUM_REGS];

  always_ff @(posedge CLK) begin
    if (WE3) rf[A3] <= WD3;
  end

  assign RD1 = rf[A1];
  assign RD2 = rf[A2];

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a (possibly wrapping) register range on a spare read port and streams (addr, data) words.
// START to first OUT_VALID is 2 edges; one word per 2 cycles at best; holds each word until OUT_READY.
module regfile_dump_reader #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] FIRST_ADDR,
  input  logic [ADDR_W-1:0] LAST_ADDR,
  output logic [ADDR_W-1:0] RA,
  input  logic [DATA_W-1:0] RD,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ADDR_W-1:0] OUT_ADDR,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              BUSY,
  output logic              DONE
);

  import regfile_pkg::*;

  if (NUM_REGS != 2**ADDR_W) begin : g_bad_size
    $error("regfile_dump_reader: NUM_REGS must equal 2**ADDR_W");
  end

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] last_q;
  logic              hs;
  logic              at_last;

  assign hs      = OUT_VALID & OUT_READY;
  assign at_last = (OUT_ADDR == last_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ABORT outranks everything outside IDLE, and also masks START inside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (START && !ABORT) state_d = READ;
      READ: state_d = ABORT ? IDLE : SEND;
      SEND: begin
        if (ABORT)   state_d = IDLE;
        else if (hs) state_d = at_last ? FIN : READ;
      end
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state_q != IDLE);
    DONE = (state_q == FIN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RA        <= '0;
      last_q    <= '0;
      OUT_VALID <= 1'b0;
      OUT_ADDR  <= '0;
      OUT_DATA  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START && !ABORT) begin
            last_q <= LAST_ADDR;
            RA     <= FIRST_ADDR;
          end
        end
        READ: begin
          if (ABORT) begin
            OUT_VALID <= 1'b0;
          end else begin
            OUT_DATA  <= RD;
            OUT_ADDR  <= RA;
            OUT_VALID <= 1'b1;
          end
        end
        SEND: begin
          if (ABORT) begin
            OUT_VALID <= 1'b0;
          end else if (hs) begin
            OUT_VALID <= 1'b0;
            // Natural ADDR_W overflow gives the 31 -> 0 wrap.
            if (!at_last) RA <= RA + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench: register_file + regfile_dump_reader with RA->A2 and RD2->RD.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  logic              CLK;
  logic              RST_N;
  logic              START;
  logic              ABORT;
  logic [ADDR_W-1:0] FIRST_ADDR;
  logic [ADDR_W-1:0] LAST_ADDR;
  logic [ADDR_W-1:0] RA;
  logic [DATA_W-1:0] RD;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [ADDR_W-1:0] OUT_ADDR;
  logic [DATA_W-1:0] OUT_DATA;
  logic              BUSY;
  logic              DONE;

  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic [DATA_W-1:0] rd1;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] q_addr [$];
  logic [DATA_W-1:0] q_data [$];
  int                n_done;

  register_file u_rf (
    .CLK (CLK), .WE3 (WE3), .A1 (5'd0), .A2 (RA), .A3 (A3),
    .WD3 (WD3), .RD1 (rd1), .RD2 (RD)
  );

  regfile_dump_reader dut (
    .CLK (CLK), .RST_N (RST_N), .START (START), .ABORT (ABORT),
    .FIRST_ADDR (FIRST_ADDR), .LAST_ADDR (LAST_ADDR), .RA (RA), .RD (RD),
    .OUT_VALID (OUT_VALID), .OUT_READY (OUT_READY), .OUT_ADDR (OUT_ADDR),
    .OUT_DATA (OUT_DATA), .BUSY (BUSY), .DONE (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rf_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    WE3 = 1'b1; A3 = a; WD3 = d;
    tick();
    WE3 = 1'b0;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
    FIRST_ADDR = f; LAST_ADDR = l; START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  // Records every accepted word and DONE pulse until the reader goes idle or the budget runs out.
  task automatic collect(input int budget);
    q_addr.delete(); q_data.delete(); n_done = 0;
    for (int c = 0; c < budget; c++) begin
      if (OUT_VALID && OUT_READY) begin
        q_addr.push_back(OUT_ADDR);
        q_data.push_back(OUT_DATA);
      end
      if (DONE) n_done++;
      if (!BUSY) break;
      tick();
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b1; START = 0; ABORT = 0; FIRST_ADDR = 0; LAST_ADDR = 0;
    OUT_READY = 0; WE3 = 0; A3 = 0; WD3 = 0;
    #2 RST_N = 1'b0;
    #1;
    checks++; if ({OUT_VALID, BUSY, DONE} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got v/b/d=%b%b%b want 000", OUT_VALID, BUSY, DONE); end
    checks++; if (RA !== 5'd0 || OUT_ADDR !== 5'd0) begin errors++;
      $display("FAIL reset_addr got ra=%0d out_addr=%0d want 0", RA, OUT_ADDR); end
    checks++; if (OUT_DATA !== 32'h0) begin errors++;
      $display("FAIL reset_data got %h want 0", OUT_DATA); end
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < 32; i++) rf_write(5'(i), 32'h1000_0000 + i);
    OUT_READY = 1'b1;
    pulse_start(5'd0, 5'd31);
    checks++; if (OUT_VALID !== 1'b0 || BUSY !== 1'b1) begin errors++;
      $display("FAIL full_lat1 got valid=%b busy=%b want 0/1", OUT_VALID, BUSY); end
    tick();
    checks++; if (OUT_VALID !== 1'b1 || OUT_ADDR !== 5'd0) begin errors++;
      $display("FAIL full_lat2 got valid=%b addr=%0d want 1/0", OUT_VALID, OUT_ADDR); end
    collect(200);
    checks++; if (q_addr.size() != 32) begin errors++;
      $display("FAIL full_count got %0d want 32", q_addr.size()); end
    for (int i = 0; i < 32; i++) begin
      logic [ADDR_W-1:0] ga;
      logic [DATA_W-1:0] gd;
      ga = (i < q_addr.size()) ? q_addr[i] : 'x;
      gd = (i < q_data.size()) ? q_data[i] : 'x;
      checks++; if (ga !== 5'(i) || gd !== 32'h1000_0000 + i) begin errors++;
        $display("FAIL full_word%0d got %0d:%h want %0d:%h", i, ga, gd, i, 32'h1000_0000 + i); end
    end
    checks++; if (n_done != 1 || BUSY !== 1'b0) begin errors++;
      $display("FAIL full_done got done=%0d busy=%b want 1/0", n_done, BUSY); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a [4];
    exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0; exp_a[3] = 5'd1;
    OUT_READY = 1'b1;
    pulse_start(5'd30, 5'd1);
    collect(100);
    checks++; if (q_addr.size() != 4 || n_done != 1) begin errors++;
      $display("FAIL wrap_count got words=%0d done=%0d want 4/1", q_addr.size(), n_done); end
    for (int i = 0; i < 4; i++) begin
      logic [ADDR_W-1:0] ga;
      logic [DATA_W-1:0] gd;
      ga = (i < q_addr.size()) ? q_addr[i] : 'x;
      gd = (i < q_data.size()) ? q_data[i] : 'x;
      checks++; if (ga !== exp_a[i] || gd !== 32'h1000_0000 + 32'(exp_a[i])) begin errors++;
        $display("FAIL wrap_word%0d got %0d:%h want %0d", i, ga, gd, exp_a[i]); end
    end
  endtask

  task automatic test_backpressure();
    rf_write(5'd5, 32'hDEAD_BEEF);
    OUT_READY = 1'b0;
    pulse_start(5'd5, 5'd5);
    tick();
    for (int i = 0; i < 7; i++) begin
      checks++; if (OUT_VALID !== 1'b1 || OUT_ADDR !== 5'd5 || OUT_DATA !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b %0d:%h want 1 5:deadbeef", i, OUT_VALID, OUT_ADDR, OUT_DATA);
      end
      tick();
    end
    OUT_READY = 1'b1;
    tick();
    checks++; if (DONE !== 1'b1 || OUT_VALID !== 1'b0) begin errors++;
      $display("FAIL bp_accept got done=%b valid=%b want 1/0", DONE, OUT_VALID); end
    tick();
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++;
      $display("FAIL bp_idle got done=%b busy=%b want 0/0", DONE, BUSY); end
  endtask

  task automatic test_abort();
    int n = 0;
    int dones = 0;
    bit fired = 0;
    OUT_READY = 1'b1;
    pulse_start(5'd0, 5'd31);
    for (int c = 0; c < 100; c++) begin
      if (OUT_VALID && OUT_READY) begin
        if (n == 3) begin ABORT = 1'b1; fired = 1; break; end
        n++;
      end
      tick();
    end
    checks++; if (!fired) begin errors++;
      $display("FAIL abort_reach got words=%0d want 3 before abort", n); end
    tick();
    ABORT = 1'b0;
    checks++; if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin errors++;
      $display("FAIL abort_idle got v/b/d=%b%b%b want 000", OUT_VALID, BUSY, DONE); end
    for (int c = 0; c < 4; c++) begin
      if (OUT_VALID || DONE) dones++;
      tick();
    end
    checks++; if (dones != 0) begin errors++;
      $display("FAIL abort_quiet got %0d active cycles want 0", dones); end

    ABORT = 1'b1;
    pulse_start(5'd4, 5'd4);
    ABORT = 1'b0;
    checks++; if (BUSY !== 1'b0) begin errors++;
      $display("FAIL abort_start_idle got busy=%b want 0", BUSY); end

    OUT_READY = 1'b0;
    pulse_start(5'd2, 5'd2);
    tick();
    pulse_start(5'd9, 5'd9);
    checks++; if (OUT_VALID !== 1'b1 || OUT_ADDR !== 5'd2) begin errors++;
      $display("FAIL busy_start got v=%b addr=%0d want 1/2", OUT_VALID, OUT_ADDR); end
    OUT_READY = 1'b1;
    tick();
    checks++; if (DONE !== 1'b1) begin errors++;
      $display("FAIL busy_start_done got done=%b want 1", DONE); end
    tick();
    checks++; if (BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin errors++;
      $display("FAIL busy_start_norestart got busy=%b valid=%b want 0/0", BUSY, OUT_VALID); end
  endtask

  task automatic test_async_reset();
    OUT_READY = 1'b0;
    pulse_start(5'd0, 5'd31);
    tick();
    #2 RST_N = 1'b0;
    #1;
    checks++; if (OUT_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin errors++;
      $display("FAIL arst_immediate got v/b/d=%b%b%b want 000", OUT_VALID, BUSY, DONE); end
    tick();
    RST_N = 1'b1;
    tick();
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++;
      $display("FAIL arst_after got busy=%b done=%b want 0/0", BUSY, DONE); end
    OUT_READY = 1'b1;
    pulse_start(5'd7, 5'd7);
    collect(50);
    checks++; if (q_addr.size() != 1 || n_done != 1) begin errors++;
      $display("FAIL arst_redump_count got words=%0d done=%0d want 1/1", q_addr.size(), n_done); end
    else begin
      checks++; if (q_addr[0] !== 5'd7 || q_data[0] !== 32'h1000_0007) begin errors++;
        $display("FAIL arst_redump_word got %0d:%h want 7:10000007", q_addr[0], q_data[0]); end
    end
  endtask

  task automatic test_concurrent_write();
    OUT_READY = 1'b1;
    pulse_start(5'd3, 5'd3);
    WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h55;
    tick();
    WE3 = 1'b0;
    checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 32'h1000_0003) begin errors++;
      $display("FAIL cw_old got v=%b data=%h want 1/10000003", OUT_VALID, OUT_DATA); end
    collect(20);
    pulse_start(5'd3, 5'd3);
    collect(20);
    checks++; if (q_data.size() != 1 || q_data[0] !== 32'h55) begin errors++;
      $display("FAIL cw_new got words=%0d data=%h want 1/55", q_data.size(),
               (q_data.size() > 0) ? q_data[0] : 32'hx); end
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_wrap();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_concurrent_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
